// File: rtl/roi_downsampler_28.sv
// Averages 10x10 pixel cells of a fixed 280x280 region of a raster-scanned grey
// frame into a 28x28 image, writing each cell one cycle after its last pixel.
module roi_downsampler_28 #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter bit INVERT   = 1'b1
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        pix_we,
   input  logic [18:0] pix_addr,
   input  logic [7:0]  pix_data,
   input  logic        frame_end,
   input  logic [9:0]  box_left,
   input  logic [9:0]  box_up,
   output logic        out_we,
   output logic [9:0]  out_addr,
   output logic [7:0]  out_data,
   output logic        frame_done,
   output logic        frame_abort,
   output logic        busy
);
   localparam int ROI  = 280;
   localparam int GRID = 28;
   localparam int CW   = 12;
   localparam logic [CW-1:0] LEFT_MAX = CW'(H_ACTIVE - ROI);
   localparam logic [CW-1:0] UP_MAX   = CW'(V_ACTIVE - ROI);
   localparam logic [CW-1:0] X_LAST   = CW'(H_ACTIVE - 1);

   typedef enum logic {IDLE, ACCUM} state_t;
   state_t state;

   logic [CW-1:0] x, y, left_eff, up_eff;
   logic [3:0]    sx, sy;
   logic [4:0]    cx, cy;
   logic [14:0]   acc [GRID];

   logic          start, take, hit, cell_end, last_cell, abort;
   logic [CW-1:0] cur_x, cur_y, cur_left, cur_up;
   logic [3:0]    cur_sx, cur_sy, nxt_sx, nxt_sy;
   logic [4:0]    cur_cx, cur_cy, nxt_cx, nxt_cy;
   logic [14:0]   acc_sum;
   logic [24:0]   product;
   logic [7:0]    avg;

   // An address-0 pixel starts a fresh frame: its position, box and cell
   // counters come from reset values rather than the registered ones.
   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      start    = pix_we && (pix_addr == '0);
      take     = start || (state == ACCUM && pix_we);
      cur_x    = start ? '0 : x;
      cur_y    = start ? '0 : y;
      cur_left = start ? ((CW'(box_left) > LEFT_MAX) ? LEFT_MAX : CW'(box_left)) : left_eff;
      cur_up   = start ? ((CW'(box_up) > UP_MAX) ? UP_MAX : CW'(box_up)) : up_eff;
      cur_sx   = start ? '0 : sx;
      cur_sy   = start ? '0 : sy;
      cur_cx   = start ? '0 : cx;
      cur_cy   = start ? '0 : cy;
      hit      = take && (cur_x >= cur_left) && (cur_x < cur_left + CW'(ROI)) &&
                 (cur_y >= cur_up) && (cur_y < cur_up + CW'(ROI));
      acc_sum   = acc[cur_cx] + 15'(pix_data);
      cell_end  = hit && (cur_sx == 4'd9) && (cur_sy == 4'd9);
      last_cell = cell_end && (cur_cx == 5'd27) && (cur_cy == 5'd27);
      abort     = (state == ACCUM) && !last_cell && (start || frame_end);
      product   = 25'(acc_sum) * 25'd655;
      avg       = product[23:16];
      nxt_sx = cur_sx;
      nxt_sy = cur_sy;
      nxt_cx = cur_cx;
      nxt_cy = cur_cy;
      if (hit) begin
         if (cur_sx == 4'd9) begin
            nxt_sx = '0;
            if (cur_cx == 5'd27) begin
               nxt_cx = '0;
               if (cur_sy == 4'd9) begin
                  nxt_sy = '0;
                  nxt_cy = cur_cy + 5'd1;
               end else begin
                  nxt_sy = cur_sy + 4'd1;
               end
            end else begin
               nxt_cx = cur_cx + 5'd1;
            end
         end else begin
            nxt_sx = cur_sx + 4'd1;
         end
      end
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge pclk) begin
      if (rst) begin
         state       <= IDLE;
         x           <= '0;
         y           <= '0;
         left_eff    <= '0;
         up_eff      <= '0;
         sx          <= '0;
         sy          <= '0;
         cx          <= '0;
         cy          <= '0;
         out_we      <= 1'b0;
         out_addr    <= '0;
         out_data    <= '0;
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
      end else begin
         out_we      <= cell_end && !abort;
         frame_done  <= last_cell;
         frame_abort <= abort;
         if (cell_end && !abort) begin
            out_addr <= 10'(cur_cy) * 10'd28 + 10'(cur_cx);
            out_data <= INVERT ? 8'd255 - avg : avg;
         end
         if (take) begin
            if (cur_x == X_LAST) begin
               x <= '0;
               y <= cur_y + CW'(1);
            end else begin
               x <= cur_x + CW'(1);
               y <= cur_y;
            end
            left_eff <= cur_left;
            up_eff   <= cur_up;
            sx       <= nxt_sx;
            sy       <= nxt_sy;
            cx       <= nxt_cx;
            cy       <= nxt_cy;
         end
         if (start)
            state <= ACCUM;
         else if (state == ACCUM && (last_cell || frame_end))
            state <= IDLE;
      end
   end

   // NOTE: the accumulator row is not reset; every cell reloads it on its first pixel.
   always_ff @(posedge pclk) begin
      if (hit)
         acc[cur_cx] <= (cur_sx == 4'd0 && cur_sy == 4'd0) ? 15'(pix_data) : acc_sum;
   end

   assign busy = (state == ACCUM);

endmodule

// File: tb/tb_roi_downsampler_28.sv
// Directed bench: two 280x280 instances (plain and inverted) run full frames and a reset,
// while a 290x290 instance covers box clamping, gapped input, restart and abort.
module tb_roi_downsampler_28;
   logic        pclk;
   logic        rst_ab, we_ab, fe_ab;
   logic [18:0] addr_ab;
   logic [7:0]  data_a, data_b;
   logic        a_we, a_done, a_abort, a_busy, b_we, b_done, b_abort, b_busy;
   logic [9:0]  a_addr, b_addr;
   logic [7:0]  a_data, b_data;

   logic        rst_c, we_c, fe_c;
   logic [18:0] addr_c;
   logic [7:0]  data_c;
   logic [9:0]  bl_c, bu_c;
   logic        c_we, c_done, c_abort, c_busy;
   logic [9:0]  c_addr;
   logic [7:0]  c_data;

   int n_vec, n_bad;
   int c_err_we, c_err_data, c_emit;

   roi_downsampler_28 #(.H_ACTIVE(280), .V_ACTIVE(280), .INVERT(1'b0)) dut_a (
      .pclk(pclk), .rst(rst_ab), .pix_we(we_ab), .pix_addr(addr_ab), .pix_data(data_a),
      .frame_end(fe_ab), .box_left(10'd0), .box_up(10'd0), .out_we(a_we), .out_addr(a_addr),
      .out_data(a_data), .frame_done(a_done), .frame_abort(a_abort), .busy(a_busy));

   roi_downsampler_28 #(.H_ACTIVE(280), .V_ACTIVE(280), .INVERT(1'b1)) dut_b (
      .pclk(pclk), .rst(rst_ab), .pix_we(we_ab), .pix_addr(addr_ab), .pix_data(data_b),
      .frame_end(fe_ab), .box_left(10'd0), .box_up(10'd0), .out_we(b_we), .out_addr(b_addr),
      .out_data(b_data), .frame_done(b_done), .frame_abort(b_abort), .busy(b_busy));

   roi_downsampler_28 #(.H_ACTIVE(290), .V_ACTIVE(290), .INVERT(1'b0)) dut_c (
      .pclk(pclk), .rst(rst_c), .pix_we(we_c), .pix_addr(addr_c), .pix_data(data_c),
      .frame_end(fe_c), .box_left(bl_c), .box_up(bu_c), .out_we(c_we), .out_addr(c_addr),
      .out_data(c_data), .frame_done(c_done), .frame_abort(c_abort), .busy(c_busy));

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int pat(input int x, input int y);
      return (3 * x + 7 * y) & 255;
   endfunction

   function automatic int cell_exp(input int l, input int u, input int cx, input int cy);
      int s = 0;
      for (int dy = 0; dy < 10; dy++)
         for (int dx = 0; dx < 10; dx++)
            s += pat(l + cx * 10 + dx, u + cy * 10 + dy);
      return (s * 655) >>> 16;
   endfunction

   task automatic drive_ab(input logic we, input int addr, input int da, input int db, input logic fe);
      @(negedge pclk);
      we_ab = we; addr_ab = 19'(addr); data_a = 8'(da); data_b = 8'(db); fe_ab = fe;
      @(posedge pclk);
      #1;
   endtask

   // One cycle on instance C, then the outputs are compared with the cell model.
   task automatic drive_c(input bit live, input logic we, input int x, input int y,
                          input logic fe, input int l, input int u);
      bit exp_we;
      int ea;
      @(negedge pclk);
      we_c = we; addr_c = 19'(y * 290 + x); data_c = 8'(pat(x, y)); fe_c = fe;
      @(posedge pclk);
      #1;
      exp_we = live && we && x >= l && x < l + 280 && y >= u && y < u + 280 &&
               ((x - l) % 10 == 9) && ((y - u) % 10 == 9);
      if (c_we !== exp_we) c_err_we++;
      if (exp_we) begin
         c_emit++;
         ea = ((y - u) / 10) * 28 + (x - l) / 10;
         if (c_addr != 10'(ea) || c_data != 8'(cell_exp(l, u, (x - l) / 10, (y - u) / 10)))
            c_err_data++;
      end
   endtask

   task automatic run_ab();
      int cnt, bad, order, timing, done_cnt, done_addr, done_we, abort_cnt, cnt_b, bad_b, exp_addr;
      bit exp_we;
      rst_ab = 1'b0;
      drive_ab(1'b0, 0, 0, 0, 1'b1);
      check("ab_idle_frame_end", a_abort, 0);
      drive_ab(1'b1, 37, 9, 9, 1'b0);
      check("ab_idle_nonzero_addr", a_busy, 0);
      cnt = 0; bad = 0;
      for (int i = 0; i < 2810; i++) begin
         drive_ab(1'b1, i, 200, 255, 1'b0);
         if (a_we) begin
            cnt++;
            if (a_data != 8'd199) bad++;
         end
      end
      check("pre_rst_cells", cnt, 28);
      check("pre_rst_data", bad, 0);
      check("busy_mid_frame", a_busy, 1);
      rst_ab = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive_ab(1'b1, 2810 + i, 200, 255, 1'b0);
         check("rst_outputs_a", int'({a_we, a_done, a_abort, a_busy, a_addr, a_data}), 0);
      end
      rst_ab = 1'b0;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         drive_ab(1'b1, 2812 + i, 200, 255, 1'b0);
         if (a_we) cnt++;
      end
      check("post_rst_no_we", cnt, 0);
      check("post_rst_idle", a_busy, 0);
      cnt = 0; bad = 0; order = 0; timing = 0; done_cnt = 0; done_addr = -1; done_we = 0;
      abort_cnt = 0; cnt_b = 0; bad_b = 0; exp_addr = 0;
      for (int i = 0; i < 280 * 280; i++) begin
         drive_ab(1'b1, i, 200, 255, i == 280 * 280 - 1);
         exp_we = ((i % 280) % 10 == 9) && ((i / 280) % 10 == 9);
         if (a_we !== exp_we) timing++;
         if (a_we) begin
            cnt++;
            if (a_data != 8'd199) bad++;
            if (a_addr != 10'(exp_addr)) order++;
            exp_addr++;
         end
         if (b_we) begin
            cnt_b++;
            if (b_data != 8'd1) bad_b++;
         end
         if (a_done) begin
            done_cnt++; done_addr = a_addr; done_we = a_we;
         end
         if (a_abort) abort_cnt++;
      end
      check("full_cells_a", cnt, 784);
      check("full_data_199", bad, 0);
      check("full_addr_order", order, 0);
      check("full_we_latency", timing, 0);
      check("frame_done_count", done_cnt, 1);
      check("frame_done_addr", done_addr, 783);
      check("frame_done_with_we", done_we, 1);
      check("no_abort_on_last", abort_cnt, 0);
      check("full_cells_b", cnt_b, 784);
      check("invert_data_1", bad_b, 0);
      drive_ab(1'b0, 0, 0, 0, 1'b0);
      check("done_one_cycle", a_done, 0);
      check("idle_after_done", a_busy, 0);
   endtask

   task automatic run_c();
      int first0 = -1;
      rst_c = 1'b0; bl_c = 10'd500; bu_c = 10'd300;
      c_err_we = 0; c_err_data = 0; c_emit = 0;
      drive_c(1'b0, 1'b0, 0, 0, 1'b1, 0, 0);
      check("c_idle_frame_end", c_abort, 0);
      // Box (500,300) clamps to (10,10); the mid-frame box change must be ignored.
      for (int i = 0; i < 20 * 290; i++) begin
         if (i == 100) begin
            bl_c = 10'd0; bu_c = 10'd0;
         end
         drive_c(1'b1, 1'b1, i % 290, i / 290, 1'b0, 10, 10);
         if (c_we && c_addr == 10'd0) first0 = c_data;
      end
      check("clamp_cell0_value", first0, 144);
      check("clamp_emits", c_emit, 28);
      check("clamp_we_timing", c_err_we, 0);
      check("clamp_data", c_err_data, 0);
      drive_c(1'b0, 1'b0, 0, 0, 1'b1, 10, 10);
      check("fe_abort_pulse", c_abort, 1);
      check("fe_busy_low", c_busy, 0);
      drive_c(1'b0, 1'b0, 0, 0, 1'b0, 10, 10);
      check("abort_one_cycle", c_abort, 0);
      c_err_we = 0; c_err_data = 0; c_emit = 0;
      for (int i = 0; i < 10 * 290; i++) begin
         drive_c(1'b1, 1'b1, i % 290, i / 290, 1'b0, 0, 0);
         repeat (2) drive_c(1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
      end
      check("gapped_emits", c_emit, 28);
      check("gapped_we_latency", c_err_we, 0);
      check("gapped_data", c_err_data, 0);
      c_err_we = 0; c_err_data = 0; c_emit = 0;
      drive_c(1'b1, 1'b1, 0, 0, 1'b0, 0, 0);
      check("restart_abort", c_abort, 1);
      check("restart_busy", c_busy, 1);
      for (int i = 1; i <= 149 * 290 + 90; i++)
         drive_c(1'b1, 1'b1, i % 290, i / 290, 1'b0, 0, 0);
      check("pre_abort_emits", c_emit, 401);
      check("pre_abort_we_timing", c_err_we, 0);
      check("pre_abort_data", c_err_data, 0);
      drive_c(1'b0, 1'b0, 0, 0, 1'b1, 0, 0);
      check("mid_abort_pulse", c_abort, 1);
      check("mid_abort_busy", c_busy, 0);
      c_err_we = 0;
      for (int i = 149 * 290 + 91; i < 149 * 290 + 400; i++)
         drive_c(1'b0, 1'b1, i % 290, i / 290, 1'b0, 0, 0);
      check("no_we_after_abort", c_err_we, 0);
      check("stays_idle_after_abort", c_busy, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: run exceeded its time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_vec = 0; n_bad = 0;
      rst_ab = 1'b1; we_ab = 1'b0; addr_ab = '0; data_a = '0; data_b = '0; fe_ab = 1'b0;
      rst_c = 1'b1; we_c = 1'b0; addr_c = '0; data_c = '0; fe_c = 1'b0; bl_c = '0; bu_c = '0;
      repeat (3) @(posedge pclk);
      #1;
      check("reset_a", int'({a_we, a_done, a_abort, a_busy, a_addr, a_data}), 0);
      check("reset_c", int'({c_we, c_done, c_abort, c_busy, c_addr, c_data}), 0);
      fork
         run_ab();
         run_c();
      join
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
